// File: rtl/xbar_pkg.sv
// Shared types and helpers for the cross-bar slave-side arbiter.
// Request entries, grant FSM states and the round-robin pick function.
package xbar_pkg;

  localparam int          XBAR_AWIDTH = 32;
  localparam int          XBAR_DWIDTH = 32;
  localparam int unsigned XBAR_MAX_M  = 16;
  localparam int          XBAR_IDX_W  = 4;

  typedef struct packed {
    logic                   we;
    logic [XBAR_AWIDTH-1:0] addr;
    logic [XBAR_DWIDTH-1:0] wdata;
  } xbar_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // First set bit of req_vec strictly after ptr, wrapping modulo n.
  // Passing ptr = n-1 turns this into a lowest-index-first priority pick.
  function automatic logic [XBAR_IDX_W-1:0] rr_pick(
    input logic [XBAR_MAX_M-1:0] req_vec,
    input logic [XBAR_IDX_W-1:0] ptr,
    input int unsigned           n
  );
    logic [XBAR_IDX_W-1:0] pick;
    logic                  found;
    int unsigned           idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= XBAR_MAX_M; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!found && (i <= n) && req_vec[idx[XBAR_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[XBAR_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xbar_req_fifo.sv
// Per-master request FIFO with wrap-bit pointers; head is the next entry to pop.
// Push is ignored when full, pop is ignored when empty.
module xbar_req_fifo
  import xbar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign not_empty = (wr_ptr_r != rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && not_empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Read and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Slave-side arbiter: per-master request FIFOs feeding a round-robin grant FSM,
// one transaction in flight, read data routed back to the issuing master.
// Optional macro XBAR_ARB_PRIO_EN adds prio_mode (fixed lowest-index priority).
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MASTER_NUM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [MASTER_NUM-1:0]        m_req_valid,
  output logic [MASTER_NUM-1:0]        m_req_ready,
  input  logic [MASTER_NUM-1:0]        m_req_we,
  input  logic [MASTER_NUM*AWIDTH-1:0] m_req_addr,
  input  logic [MASTER_NUM*DWIDTH-1:0] m_req_wdata,
  output logic [MASTER_NUM-1:0]        m_resp_valid,
  output logic [DWIDTH-1:0]            m_resp_rdata,
`ifdef XBAR_ARB_PRIO_EN
  input  logic                         prio_mode,
`endif
  output logic                         s_req,
  output logic                         s_we,
  output logic [AWIDTH-1:0]            s_addr,
  output logic [DWIDTH-1:0]            s_wdata,
  input  logic                         s_ack,
  input  logic                         s_resp_valid,
  input  logic [DWIDTH-1:0]            s_rdata
);

  localparam int IW = $clog2(MASTER_NUM);
  localparam int EW = 1 + AWIDTH + DWIDTH;

  logic [MASTER_NUM-1:0] push_s;
  logic [MASTER_NUM-1:0] pop_s;
  logic [MASTER_NUM-1:0] full_s;
  logic [MASTER_NUM-1:0] not_empty_s;
  logic [EW-1:0]         din_s  [MASTER_NUM];
  logic [EW-1:0]         head_s [MASTER_NUM];

  arb_state_e            state_r;
  arb_state_e            state_nxt_s;
  logic [IW-1:0]         gnt_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         gnt_idx_s;
  logic [XBAR_IDX_W-1:0] pick_full_s;
  logic [XBAR_MAX_M-1:0] req_pad_s;
  logic [EW-1:0]         sel_head_s;
  logic                  use_prio_s;
  logic                  grant_s;
  logic                  ack_s;
  logic                  resp_s;

  assign m_req_ready = ~full_s;
  assign push_s      = m_req_valid & m_req_ready;

  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_fifo
    assign din_s[g] = {m_req_we[g], m_req_addr[g*AWIDTH +: AWIDTH], m_req_wdata[g*DWIDTH +: DWIDTH]};

    xbar_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk       (aclk),
      .rst_n     (aresetn),
      .push      (push_s[g]),
      .pop       (pop_s[g]),
      .din       (din_s[g]),
      .head      (head_s[g]),
      .not_empty (not_empty_s[g]),
      .full      (full_s[g])
    );
  end

`ifdef XBAR_ARB_PRIO_EN
  assign use_prio_s = prio_mode;
`else
  assign use_prio_s = 1'b0;
`endif

  // Candidate grant: priority mode is a round-robin pick anchored at the last index.
  always_comb begin
    req_pad_s                   = '0;
    req_pad_s[MASTER_NUM-1:0]   = not_empty_s;
    if (use_prio_s) begin
      pick_full_s = rr_pick(req_pad_s, XBAR_IDX_W'(MASTER_NUM - 1), MASTER_NUM);
    end else begin
      pick_full_s = rr_pick(req_pad_s, XBAR_IDX_W'(rr_ptr_r), MASTER_NUM);
    end
  end

  assign gnt_idx_s  = pick_full_s[IW-1:0];
  assign sel_head_s = head_s[gnt_idx_s];

  // Grant FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus single-cycle grant/ack/response events.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = '0;
    grant_s     = 1'b0;
    ack_s       = 1'b0;
    resp_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (|not_empty_s) begin
          grant_s            = 1'b1;
          pop_s[gnt_idx_s]   = 1'b1;
          state_nxt_s        = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (s_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = s_we ? IDLE : RESP;
        end else begin
          state_nxt_s = REQ;
        end
      end
      RESP: begin
        if (s_resp_valid) begin
          resp_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Slave request channel; the payload is held until the next grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_req   <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      gnt_r   <= '0;
    end else if (grant_s) begin
      s_req                   <= 1'b1;
      {s_we, s_addr, s_wdata} <= sel_head_s;
      gnt_r                   <= gnt_idx_s;
    end else if (ack_s) begin
      s_req <= 1'b0;
    end
  end

  // Round-robin pointer; frozen while fixed priority is selected.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_r <= IW'(MASTER_NUM - 1);
    end else if (grant_s && !use_prio_s) begin
      rr_ptr_r <= gnt_idx_s;
    end
  end

  // Read data goes back only to the master that owns the in-flight read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_resp_valid <= '0;
      m_resp_rdata <= '0;
    end else begin
      m_resp_valid <= '0;
      if (resp_s) begin
        m_resp_valid[gnt_r] <= 1'b1;
        m_resp_rdata        <= s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Bench for xbar_rr_arbiter: queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_xbar_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int M  = 4;
  localparam int D  = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [M-1:0]    m_req_valid, m_req_ready, m_req_we, m_resp_valid;
  logic [M*AW-1:0] m_req_addr;
  logic [M*DW-1:0] m_req_wdata;
  logic [DW-1:0]   m_resp_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic            s_req, s_we, s_ack, s_resp_valid;
`ifdef XBAR_ARB_PRIO_EN
  logic            prio_mode = 1'b0;
`endif

  always #5 aclk = ~aclk;

  xbar_rr_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MASTER_NUM(M), .FIFO_DEPTH(D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
`ifdef XBAR_ARB_PRIO_EN
    .prio_mode(prio_mode),
`endif
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [64:0]  mb [M][D];
  int           mc [M];
  int           mh [M];
  int           ph;          // 0 waiting to grant, 1 request outstanding, 2 awaiting read data
  int           ptr, gnt, pk;
  logic         found, use_prio, model_on = 1'b0;
  logic [64:0]  cur;
  logic [DW-1:0] last_rd;
  logic [M-1:0] pulse, acc, exp_rdy;

  // issue / response log
  logic [AW-1:0] iss_a [512];
  logic [DW-1:0] iss_d [512];
  logic          iss_w [512];
  int            n_iss = 0;
  logic [M-1:0]  rsp_v [64];
  logic [DW-1:0] rsp_d [64];
  int            n_rsp = 0;
  logic          s_req_q = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < M; i++) begin mc[i] = 0; mh[i] = 0; end
      ph = 0; ptr = M - 1; gnt = 0; cur = '0; last_rd = '0; pulse = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      for (int i = 0; i < M; i++) acc[i] = m_req_valid[i] && (mc[i] < D);
      pulse = '0;
      use_prio = 1'b0;
`ifdef XBAR_ARB_PRIO_EN
      use_prio = prio_mode;
`endif
      if (ph == 0) begin
        found = 1'b0; pk = 0;
        if (use_prio) begin
          for (int k = 0; k < M; k++) if (!found && mc[k] > 0) begin found = 1'b1; pk = k; end
        end else begin
          for (int k = 1; k <= M; k++) if (!found && mc[(ptr + k) % M] > 0) begin found = 1'b1; pk = (ptr + k) % M; end
        end
        if (found) begin
          gnt = pk; cur = mb[pk][mh[pk]]; mh[pk] = (mh[pk] + 1) % D; mc[pk]--; ph = 1;
          if (!use_prio) ptr = pk;
        end
      end else if (ph == 1) begin
        if (s_ack) ph = cur[64] ? 0 : 2;
      end else if (ph == 2) begin
        if (s_resp_valid) begin pulse[gnt] = 1'b1; last_rd = s_rdata; ph = 0; end
      end
      for (int i = 0; i < M; i++) begin
        if (acc[i]) begin
          mb[i][(mh[i] + mc[i]) % D] = {m_req_we[i], m_req_addr[i*AW +: AW], m_req_wdata[i*DW +: DW]};
          mc[i]++;
        end
      end
    end
    if (model_on) begin
      for (int i = 0; i < M; i++) exp_rdy[i] = (mc[i] < D);
      check("s_req", s_req, (ph == 1));
      check("s_payload", {s_we, s_addr, s_wdata}, cur);
      check("m_resp_valid", m_resp_valid, pulse);
      check("m_resp_rdata", m_resp_rdata, last_rd);
      check("m_req_ready", m_req_ready, exp_rdy);
    end
    if (s_req && !s_req_q && n_iss < 512) begin
      iss_a[n_iss] = s_addr; iss_d[n_iss] = s_wdata; iss_w[n_iss] = s_we; n_iss++;
    end
    if (|m_resp_valid && n_rsp < 64) begin
      rsp_v[n_rsp] = m_resp_valid; rsp_d[n_rsp] = m_resp_rdata; n_rsp++;
    end
    s_req_q = aresetn ? s_req : 1'b0;
  end

  // ---------------- slave responder ----------------
  logic          ack_always = 1'b1;
  logic          spur = 1'b0;
  int            ack_delay = 0;
  int            cnt = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr;

  always @(negedge aclk) begin
    #1;
    if (!aresetn) begin
      s_ack = 1'b0; s_resp_valid = 1'b0; cnt = 0; pend = 1'b0;
    end else begin
      s_ack = ack_always; s_resp_valid = 1'b0;
      if (ack_always) cnt = 0;
      if (s_req) begin
        if (!ack_always) begin
          if (cnt >= ack_delay) begin s_ack = 1'b1; cnt = 0; end
          else cnt++;
        end
        if (spur && cnt == 2) begin s_resp_valid = 1'b1; s_rdata = 32'hBAD0_BAD0; end
        if (s_ack && !s_we) begin pend = 1'b1; pend_addr = s_addr; end
      end else if (pend) begin
        s_resp_valid = 1'b1; s_rdata = pend_addr ^ 32'hC0DE_0000; pend = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge aclk);
    #2;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req_valid[i] = 1'b1; m_req_we[i] = we;
    m_req_addr[i*AW +: AW] = a; m_req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((ph != 0 || s_req || (mc[0] + mc[1] + mc[2] + mc[3]) != 0) && k < budget) begin
      step(); k++;
    end
    step(); step();
    check("idle_timeout", (k < budget), 1'b1);
  endtask

  logic [AW-1:0] exp_addr [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
  logic [DW-1:0] exp_rd   [4] = '{32'hC0DE_0010, 32'hC0DE_0020, 32'hC0DE_0030, 32'hC0DE_0040};
  int b, rb, k, hi, n100, viol;

  initial begin
    aresetn = 1'b0; m_req_valid = '0; m_req_we = '0; m_req_addr = '0; m_req_wdata = '0;
    s_ack = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
    repeat (3) step();
    aresetn = 1'b1;
    step();

    // four reads in one cycle: rr order from reset pointer, data routed per master
    b = n_iss; rb = n_rsp;
    for (int i = 0; i < M; i++) set_req(i, 1'b0, exp_addr[i], 32'h0);
    step();
    check("lat_t1_s_req", s_req, 1'b0);
    m_req_valid = '0;
    step();
    check("lat_t2_s_req", s_req, 1'b1);
    check("lat_t2_s_addr", s_addr, 32'h10);
    wait_idle(200);
    check("t2_n_iss", n_iss - b, 4);
    check("t2_n_rsp", n_rsp - rb, 4);
    for (int i = 0; i < M; i++) begin
      check("t2_order", iss_a[b + i], exp_addr[i]);
      check("t2_rsp_vec", rsp_v[rb + i], 4'b0001 << i);
      check("t2_rsp_data", rsp_d[rb + i], exp_rd[i]);
    end

    // master 1 fills its FIFO while a stalled write blocks the slave
    b = n_iss;
    ack_always = 1'b0; ack_delay = 20;
    set_req(0, 1'b1, 32'h900, 32'h9);
    step();
    m_req_valid = '0;
    step();
    for (int j = 0; j < 4; j++) begin
      set_req(1, 1'b1, 32'h1000 + j, 32'hA000_0000 + j);
      step();
    end
    check("t3_ready_full", m_req_ready, 4'b1101);
    set_req(1, 1'b1, 32'hDEAD, 32'hDEAD);
    step();
    m_req_valid = '0;
    check("t3_ready_still_full", m_req_ready[1], 1'b0);
    ack_always = 1'b1;
    wait_idle(200);
    check("t3_n_iss", n_iss - b, 5);
    check("t3_first", iss_a[b], 32'h900);
    for (int j = 0; j < 4; j++) begin
      check("t3_addr", iss_a[b + 1 + j], 32'h1000 + j);
      check("t3_wdata", iss_d[b + 1 + j], 32'hA000_0000 + j);
      check("t3_we", iss_w[b + 1 + j], 1'b1);
    end

    // masters 0 and 2 always busy: strict alternation
    b = n_iss; k = 0;
    set_req(0, 1'b1, 32'h100, 32'h1);
    set_req(2, 1'b1, 32'h200, 32'h2);
    while (n_iss - b < 100 && k < 1000) begin step(); k++; end
    m_req_valid = '0;
    check("t4_budget", (k < 1000), 1'b1);
    wait_idle(200);
    n100 = 0; viol = 0;
    for (int j = 0; j < 100; j++) begin
      if (iss_a[b + j] == 32'h100) n100++;
      if (j > 0 && iss_a[b + j] == iss_a[b + j - 1]) viol++;
    end
    check("t4_first_is_m2", iss_a[b], 32'h200);
    check("t4_m0_grants", n100, 50);
    check("t4_repeats", viol, 0);

    // delayed ack with a spurious read-data strobe during the request
    rb = n_rsp;
    ack_always = 1'b0; ack_delay = 5; spur = 1'b1;
    set_req(3, 1'b0, 32'h3330, 32'h0);
    step();
    m_req_valid = '0;
    step();
    hi = 0;
    while (s_req && hi < 30) begin
      check("t5_addr_stable", s_addr, 32'h3330);
      hi++; step();
    end
    check("t5_req_cycles", hi, 6);
    wait_idle(100);
    spur = 1'b0; ack_always = 1'b1;
    check("t5_n_rsp", n_rsp - rb, 1);
    check("t5_rsp_vec", rsp_v[rb], 4'b1000);
    check("t5_rsp_data", rsp_d[rb], 32'hC0DE_3330);

`ifdef XBAR_ARB_PRIO_EN
    // fixed priority favours master 0; round-robin then hands over to master 3
    set_req(0, 1'b1, 32'h100, 32'h5);
    step();
    m_req_valid = '0;
    wait_idle(50);
    prio_mode = 1'b1;
    b = n_iss; k = 0;
    set_req(0, 1'b1, 32'h100, 32'h6);
    set_req(3, 1'b1, 32'h400, 32'h7);
    while (n_iss - b < 10 && k < 200) begin step(); k++; end
    viol = 0;
    for (int j = 0; j < 10; j++) if (iss_a[b + j] != 32'h100) viol++;
    check("t6_prio_m0_only", viol, 0);
    prio_mode = 1'b0;
    b = n_iss; k = 0;
    while (n_iss == b && k < 50) begin step(); k++; end
    check("t6_rr_next_m3", iss_a[b], 32'h400);
    m_req_valid = '0;
    wait_idle(200);
`endif

    // reset while a request is outstanding and another is queued
    ack_always = 1'b0; ack_delay = 50;
    set_req(0, 1'b0, 32'h500, 32'h0);
    set_req(1, 1'b0, 32'h600, 32'h0);
    step();
    m_req_valid = '0;
    step();
    check("t1_mid_req", s_req, 1'b1);
    aresetn = 1'b0;
    step();
    check("t1_s_req_cleared", s_req, 1'b0);
    check("t1_ready_all", m_req_ready, 4'b1111);
    aresetn = 1'b1; ack_always = 1'b1;
    hi = 0;
    for (int j = 0; j < 10; j++) begin step(); if (s_req) hi++; end
    check("t1_no_stale_issue", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
